// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, access-size
// codes, owner encoding and the default DMA hold limit.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_OWN = 2'd1,
        ST_DMA_OWN = 2'd2
    } arb_state_t;

    localparam logic [1:0] BHW_BYTE = 2'd0;
    localparam logic [1:0] BHW_HALF = 2'd1;
    localparam logic [1:0] BHW_WORD = 2'd2;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int DEFAULT_MAX_HOLD = 4;

    // 32-bit increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        sat_inc32 = (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
    endfunction

endpackage

// File: rtl/dmem_arb_hold_cnt.sv
// Saturating counter of consecutive DMA grants taken while the CPU waits.
// at_limit reflects the count as it will be after this cycle, so the arbiter
// can hand the next cycle to the CPU right after the last allowed DMA grant.
module dmem_arb_hold_cnt #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int              CW    = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(MAX_HOLD);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;

    // next count: clear has priority, increment stops at the limit
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = '0;
        end else if (inc && (count_r != LIMIT)) begin
            count_nxt_s = count_r + CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign at_limit = (count_nxt_s == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one DataMemory port between the CPU load/store unit and the
// DMA loader. DMA wins contention, but after MAX_HOLD back-to-back DMA grants
// with the CPU waiting the CPU gets one cycle. Grants are the registered state.
// Optional stall statistics: define DMEM_ARBITER_STATS_EN to enable stall_count.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int AW       = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [AW-1:0] cpu_wdata,
    input  logic [1:0]    cpu_bhw,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [AW-1:0] dma_wdata,
    input  logic [1:0]    dma_bhw,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic [AW-1:0] rdata,
    output logic          rdata_valid,
    output logic          rdata_owner,
    output logic          pc_write,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic [1:0]    mem_bhw,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [AW-1:0] mem_rdata,
    output logic [31:0]   stall_count
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       ready_r;
    logic       at_limit_s;
    logic       owner_req_s;
    logic       owner_we_s;
    logic       owner_id_s;

    dmem_arb_hold_cnt #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_r != ST_DMA_OWN),
        .inc      ((state_r == ST_DMA_OWN) && cpu_req),
        .at_limit (at_limit_s)
    );

    // ready_r holds off arbitration for the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    // next owner from the live requests; DMA preferred unless its hold is used up
    always_comb begin
        state_nxt_s = ST_IDLE;
        if (!ready_r) begin
            state_nxt_s = ST_IDLE;
        end else if (cpu_req && dma_req) begin
            state_nxt_s = at_limit_s ? ST_CPU_OWN : ST_DMA_OWN;
        end else if (dma_req) begin
            state_nxt_s = ST_DMA_OWN;
        end else if (cpu_req) begin
            state_nxt_s = ST_CPU_OWN;
        end else begin
            state_nxt_s = ST_IDLE;
        end
    end

    // ownership state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign cpu_gnt = (state_r == ST_CPU_OWN);
    assign dma_gnt = (state_r == ST_DMA_OWN);

    // memory port mux from the current owner; idle drives an inert port
    always_comb begin
        owner_req_s = 1'b0;
        owner_we_s  = 1'b0;
        owner_id_s  = OWNER_CPU;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_bhw     = BHW_BYTE;
        case (state_r)
            ST_CPU_OWN: begin
                owner_req_s = cpu_req;
                owner_we_s  = cpu_we;
                owner_id_s  = OWNER_CPU;
                mem_addr    = cpu_addr;
                mem_wdata   = cpu_wdata;
                mem_bhw     = cpu_bhw;
            end
            ST_DMA_OWN: begin
                owner_req_s = dma_req;
                owner_we_s  = dma_we;
                owner_id_s  = OWNER_DMA;
                mem_addr    = dma_addr;
                mem_wdata   = dma_wdata;
                mem_bhw     = dma_bhw;
            end
            ST_IDLE: begin
                owner_req_s = 1'b0;
            end
            default: begin
                owner_req_s = 1'b0;
            end
        endcase
    end

    // a request dropped while owning issues neither a read nor a write
    assign mem_we = owner_req_s & owner_we_s;
    assign mem_re = owner_req_s & ~owner_we_s;

    // capture read data at the end of the grant cycle and flag it for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_owner <= OWNER_CPU;
        end else if (mem_re) begin
            rdata       <= mem_rdata;
            rdata_valid <= 1'b1;
            rdata_owner <= owner_id_s;
        end else begin
            rdata_valid <= 1'b0;
        end
    end

    assign pc_write = ~(cpu_req & ~cpu_gnt);

`ifdef DMEM_ARBITER_STATS_EN
    logic [31:0] stall_cnt_r;

    // count cycles in which the CPU is stalled waiting for the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (!pc_write) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_count = stall_cnt_r;
`else
    assign stall_count = 32'd0;
`endif

endmodule
